// File: rtl/led_env_pkg.sv
// Shared types and default constants for the LED envelope generator.
// Duty math is carried one bit wider than duty so sums can be saturated.
package led_env_pkg;

    localparam int DUTY_W = 14;
    localparam int CALC_W = 15;

    localparam int DEF_PERIOD   = 10000;
    localparam int DEF_PEAK     = 10000;
    localparam int DEF_SUS_LVL  = 5000;
    localparam int DEF_ATK_STEP = 20;
    localparam int DEF_DEC_STEP = 5;
    localparam int DEF_REL_STEP = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } env_state_t;

endpackage

// File: rtl/frame_timer.sv
// Free-running frame counter 0..PERIOD-1; tick marks the last cycle of a frame.
module frame_timer #(
    parameter int PERIOD = 10000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign tick       = (count_reg == LAST);
    assign count_next = tick ? '0 : count_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/led_envelope_gen.sv
// ADSR-style envelope for an LED PWM stage; state and duty advance once per frame.
module led_envelope_gen
    import led_env_pkg::*;
#(
    parameter int PERIOD   = DEF_PERIOD,
    parameter int PEAK     = DEF_PEAK,
    parameter int SUS_LVL  = DEF_SUS_LVL,
    parameter int ATK_STEP = DEF_ATK_STEP,
    parameter int DEC_STEP = DEF_DEC_STEP,
    parameter int REL_STEP = DEF_REL_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_on,
    output logic [DUTY_W-1:0] duty,
    output logic              frame_tick,
    output logic              busy
);

    localparam logic [CALC_W-1:0] PEAK_C = CALC_W'(PEAK);
    localparam logic [CALC_W-1:0] SUS_C  = CALC_W'(SUS_LVL);
    localparam logic [CALC_W-1:0] ATK_C  = CALC_W'(ATK_STEP);
    localparam logic [CALC_W-1:0] DEC_C  = CALC_W'(DEC_STEP);
    localparam logic [CALC_W-1:0] REL_C  = CALC_W'(REL_STEP);
    localparam logic [DUTY_W-1:0] PEAK_D = DUTY_W'(PEAK);

    env_state_t        state_reg;
    env_state_t        state_next;
    logic [DUTY_W-1:0] duty_reg;
    logic [DUTY_W-1:0] duty_next;
    logic [CALC_W-1:0] duty_wide;
    logic [CALC_W-1:0] duty_calc;
    logic [CALC_W-1:0] attack_sum;
    logic              tick;

    frame_timer #(
        .PERIOD(PERIOD)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign duty_wide  = {1'b0, duty_reg};
    assign attack_sum = duty_wide + ATK_C;
    // Final clamp keeps duty inside 0..PEAK even if a step overshoots.
    assign duty_next  = (duty_calc > PEAK_C) ? PEAK_D : duty_calc[DUTY_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            duty_reg  <= '0;
        end else begin
            state_reg <= state_next;
            duty_reg  <= duty_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        duty_calc  = duty_wide;
        if (tick) begin
            // Attack is entered from IDLE and RELEASE alike, starting at the current duty.
            if (key_on && (state_reg == ST_IDLE || state_reg == ST_ATTACK
                           || state_reg == ST_RELEASE)) begin
                if (attack_sum >= PEAK_C) begin
                    duty_calc  = PEAK_C;
                    state_next = ST_DECAY;
                end else begin
                    duty_calc  = attack_sum;
                    state_next = ST_ATTACK;
                end
            end else if (key_on && state_reg == ST_DECAY) begin
                if (duty_wide <= SUS_C + DEC_C) begin
                    duty_calc  = SUS_C;
                    state_next = ST_SUSTAIN;
                end else begin
                    duty_calc  = duty_wide - DEC_C;
                end
            end else if (key_on && state_reg == ST_SUSTAIN) begin
                duty_calc  = SUS_C;
            end else if (!key_on && state_reg != ST_IDLE) begin
                if (duty_wide <= REL_C) begin
                    duty_calc  = '0;
                    state_next = ST_IDLE;
                end else begin
                    duty_calc  = duty_wide - REL_C;
                    state_next = ST_RELEASE;
                end
            end
        end
    end

    always_comb begin
        duty       = duty_reg;
        frame_tick = tick;
        busy       = (state_reg != ST_IDLE);
    end

endmodule

// File: tb/tb_led_envelope_gen.sv
// Randomised and directed checks of the envelope against a per-frame behavioural model.
module tb_led_envelope_gen;

    localparam int PERIOD = 100;
    localparam int PEAK   = 100;
    localparam int SUS    = 50;
    localparam int ATK    = 10;
    localparam int DEC    = 5;
    localparam int REL    = 25;

    logic        clk;
    logic        rst_n;
    logic        key_on;
    logic [13:0] duty;
    logic        frame_tick;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int tick_no = 0;

    // Model: phase name plus duty level, advanced once per frame.
    string m_phase = "idle";
    int    m_duty  = 0;

    led_envelope_gen #(
        .PERIOD(PERIOD), .PEAK(PEAK), .SUS_LVL(SUS),
        .ATK_STEP(ATK), .DEC_STEP(DEC), .REL_STEP(REL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_on(key_on),
        .duty(duty), .frame_tick(frame_tick), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_frame(input logic k);
        if (!k) begin
            if (m_phase != "idle") begin
                m_duty  = imax(m_duty - REL, 0);
                m_phase = (m_duty == 0) ? "idle" : "release";
            end
        end else if (m_phase == "decay") begin
            m_duty  = imax(m_duty - DEC, SUS);
            m_phase = (m_duty == SUS) ? "sustain" : "decay";
        end else if (m_phase == "sustain") begin
            m_duty  = SUS;
        end else begin
            m_duty  = imin(m_duty + ATK, PEAK);
            m_phase = (m_duty == PEAK) ? "decay" : "attack";
        end
    endtask

    // Starts on a negedge right after a frame boundary; optionally glitches key_on
    // between ticks, then presents k at the tick and checks the resulting frame.
    task automatic frame(input logic k, input bit glitch);
        int edges = 0;
        while (!frame_tick && edges < 300) begin
            if (glitch && edges < 80) key_on = 1'($urandom);
            else key_on = k;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        key_on = k;
        tick_no++;
        check("tick_spacing", edges, PERIOD - 1);
        model_frame(k);
        @(posedge clk);
        #1;
        check("duty", int'(duty), m_duty);
        check("busy", int'(busy), (m_phase != "idle") ? 1 : 0);
        $display("tick %0d key=%0b duty=%0d busy=%0b model=%s/%0d",
                 tick_no, k, duty, busy, m_phase, m_duty);
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        key_on = 1'b0;
        #3;
        check("rst_duty", int'(duty), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tick", int'(frame_tick), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle frames, with key glitches between ticks that must be ignored.
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b1);
        frame(1'b0, 1'b1);

        // Held key: attack to peak, decay to sustain, hold.
        for (int i = 0; i < 24; i++) frame(1'b1, 1'b0);
        check("sustain_level", int'(duty), SUS);

        // Release from sustain: 25 then 0.
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        check("idle_after_release", int'(busy), 0);

        // Drop during attack at 30: 5 then 0.
        for (int i = 0; i < 3; i++) frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);

        // Retrigger from release at 25: next tick 35.
        for (int i = 0; i < 5; i++) frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);
        check("retrigger_duty", int'(duty), 35);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);

        // Random key sequence with run-length bias to reach every phase.
        begin
            logic k = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(0, 3) == 0) k = ~k;
                frame(k, 1'($urandom));
            end
        end
        key_on = 1'b0;
        for (int i = 0; i < 6; i++) frame(1'b0, 1'b0);

        // Asynchronous reset mid-attack at duty 40.
        for (int i = 0; i < 4; i++) frame(1'b1, 1'b0);
        check("pre_reset_duty", int'(duty), 40);
        repeat (30) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_duty", int'(duty), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_tick", int'(frame_tick), 0);
        check("async_rst_count", int'(dut.u_timer.count_reg), 0);
        m_phase = "idle";
        m_duty  = 0;
        key_on  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_envelope_gen.md
LED_ENVELOPE_GEN -- requirements
Module: led_envelope_gen

Interface
REQ-001 Parameter PERIOD, default 10000: PWM frame length in clk cycles.
REQ-002 Parameter PEAK, default 10000: attack target duty; PEAK <= PERIOD.
REQ-003 Parameter SUS_LVL, default 5000: sustain duty; SUS_LVL <= PEAK.
REQ-004 Parameter ATK_STEP, default 20; DEC_STEP, default 5; REL_STEP, default 10: duty change per frame, each >= 1.
REQ-005 clk  input  1  single system clock; all state on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 key_on  input  1  synchronous level, high while the organ key is held.
REQ-008 duty  output  14  LED on-time in clk cycles per frame, range 0..PEAK; consumed by the downstream PWM LED stage.
REQ-009 frame_tick  output  1  one-cycle pulse marking the frame boundary; duty changes only in this cycle.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 Frame counter SHALL count 0..PERIOD-1 and wrap; frame_tick SHALL be high exactly when the counter equals PERIOD-1.
REQ-012 FSM states SHALL be IDLE, ATTACK, DECAY, SUSTAIN, RELEASE; state and duty update only on frame_tick cycles.
REQ-013 key_on SHALL be sampled only on frame_tick; changes between ticks are ignored.
REQ-014 IDLE with key_on=1: go to ATTACK and apply the first ATK_STEP in the same tick.
REQ-015 ATTACK: duty += ATK_STEP; if the result >= PEAK, duty = PEAK and go to DECAY.
REQ-016 DECAY: duty -= DEC_STEP; if the result <= SUS_LVL, duty = SUS_LVL and go to SUSTAIN.
REQ-017 SUSTAIN: duty holds at SUS_LVL while key_on=1.
REQ-018 key_on=0 in ATTACK, DECAY or SUSTAIN: go to RELEASE and apply one REL_STEP in the same tick.
REQ-019 RELEASE: if duty <= REL_STEP, duty = 0 and go to IDLE; otherwise duty -= REL_STEP.
REQ-020 key_on=1 in RELEASE: go to ATTACK from the current duty (retrigger, no jump to 0) and apply ATK_STEP in the same tick.
REQ-021 Arithmetic SHALL be saturating and computed at 15 bits; duty SHALL never underflow below 0 or exceed PEAK.
REQ-022 busy SHALL fall in the same cycle that duty reaches 0 on leaving RELEASE.
REQ-023 Latency from a sampled key_on change to a duty change SHALL be 0 cycles beyond the sampling tick.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear: counter = 0, state = IDLE, duty = 0, frame_tick = 0, busy = 0, including mid-envelope.
REQ-025 After rst_n rises, the first frame_tick SHALL occur PERIOD cycles later, counter 0 through PERIOD-1.

Structure
REQ-026 Package led_env_pkg SHALL hold the state enum, DUTY_W = 14, and the default parameter constants.
REQ-027 Frame counter and tick SHALL be a sub-module frame_timer (parameter PERIOD; ports clk, rst_n, tick); the FSM and duty arithmetic stay in led_envelope_gen.

Verification
All scenarios use PERIOD=100, PEAK=100, SUS_LVL=50, ATK_STEP=10, DEC_STEP=5, REL_STEP=25.
REQ-028 Reset release with key_on=0 -> duty=0, busy=0; frame_tick pulses at cycles 100, 200, ... after reset release.
REQ-029 key_on held from reset -> duty on ticks 1..10 is 10, 20, ..., 100; ticks 11..20 are 95 down to 50; thereafter constant 50 with busy=1.
REQ-030 key_on dropped during SUSTAIN -> next ticks give duty 25, then 0; busy=0 on the tick duty reaches 0.
REQ-031 key_on dropped at duty 30 in ATTACK -> next tick 5, following tick 0, then IDLE; key_on=1 at duty 25 in RELEASE -> next tick 35 in ATTACK.
REQ-032 key_on pulsed high for 20 cycles strictly between ticks while IDLE -> duty stays 0 and busy stays 0.
REQ-033 rst_n asserted mid-ATTACK at duty 40 -> duty=0, busy=0, counter=0 asynchronously, before the next clk edge.
